// File: rtl/divu_seq_if.sv
// Operand/result bundle for divu_seq: start/sign/a/b in, q/r/busy/done/dbz out.
interface divu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (
    output start, sign, a, b,
    input  q, r, busy, done, dbz
  );

  modport slave (
    input  start, sign, a, b,
    output q, r, busy, done, dbz
  );
endinterface

// File: rtl/divu_seq.sv
// Iterative radix-2 restoring divider, signed/unsigned per operation.
// Fixed latency: WIDTH CALC cycles plus one sign-fix cycle, then a one-cycle done pulse.
module divu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic       i_clock,
  input logic       i_reset,
  divu_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_dvd;    // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;

  assign w_accept = ((r_state == StIdle) || (r_state == StDone)) && bus.start;

  // The shifted remainder needs WIDTH+1 bits so divisors >= 2^(WIDTH-1) compare correctly.
  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];
  assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_nxt = StCalc;
      StCalc:  if (r_cnt == CNT_W'(1)) w_state_nxt = StFix;
      StFix:   w_state_nxt = StDone;
      StDone:  w_state_nxt = bus.start ? StCalc : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      StCalc:  w_busy = 1'b1;
      StFix:   w_busy = 1'b1;
      StDone:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_dvd   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_dvd   <= (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      r_dvs   <= (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      r_neg_q <= bus.sign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_neg_r <= bus.sign && bus.a[WIDTH-1];
      r_zero  <= (bus.b == '0);
      r_rem   <= '0;
      r_cnt   <= CNT_W'(WIDTH);
    end else if (r_state == StCalc) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_dvd_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (r_state == StFix) begin
      r_q   <= r_zero ? '0 : (r_neg_q ? -r_dvd : r_dvd);
      r_r   <= r_zero ? '0 : (r_neg_r ? -r_rem : r_rem);
      r_dbz <= r_zero;
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.dbz  = r_dbz;
  assign bus.busy = w_busy;
  assign bus.done = w_done;

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: directed cases, handshake corners, reset abort, random ops.
module tb_divu_seq;

  localparam int unsigned W = 32;

  typedef struct {
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];

  divu_seq_if #(.WIDTH(W)) bus ();

  divu_seq #(.WIDTH(W)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truncating reference via 64-bit signed arithmetic; b==0 gives 0/0.
  function automatic void model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb_v;
    if (b == '0) begin
      q = '0;
      r = '0;
      return;
    end
    sa   = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb_v = sg ? longint'($signed(b)) : longint'({32'b0, b});
    q    = W'(sa / sb_v);
    r    = W'(sa % sb_v);
  endfunction

  task automatic start_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
    exp_t e;
    e.sg  = sg;
    e.a   = a;
    e.b   = b;
    e.q   = eq;
    e.r   = er;
    e.dbz = (b == '0);
    sb.push_back(e);
    bus.start = 1'b1;
    bus.sign  = sg;
    bus.a     = a;
    bus.b     = b;
  endtask

  // Called one edge after acceptance; returns in the done cycle.
  task automatic await_done(input string tag, input int ign_at);
    int   lat;
    int   bcnt;
    exp_t e;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 3 * W) begin
      if (bus.busy === 1'b1) bcnt++;
      if (lat == ign_at) begin
        bus.start = 1'b1;
        bus.sign  = ~bus.sign;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h0000_0003;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check({tag, ".lat"}, 64'(lat), 64'(W + 1));
    check({tag, ".busycnt"}, 64'(bcnt), 64'(W + 1));
    check({tag, ".busy_at_done"}, 64'(bus.busy), 64'(0));
    check({tag, ".sbsize"}, 64'(sb.size()), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".q"}, 64'(bus.q), 64'(e.q));
      check({tag, ".r"}, 64'(bus.r), 64'(e.r));
      check({tag, ".dbz"}, 64'(bus.dbz), 64'(e.dbz));
      if (e.b != '0) begin
        check({tag, ".ident"}, 64'(W'(bus.q * e.b + bus.r)), 64'(e.a));
      end
    end
  endtask

  task automatic run(input string tag, input logic sg, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input int ign_at);
    start_op(sg, a, b, eq, er);
    tick();
    // Scramble inputs after acceptance; the running operation must not see them.
    bus.start = 1'b0;
    bus.sign  = ~sg;
    bus.a     = $urandom;
    bus.b     = $urandom;
    await_done(tag, ign_at);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rs;
    int           dcnt;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) tick();
    check("rst.q", 64'(bus.q), 64'(0));
    check("rst.r", 64'(bus.r), 64'(0));
    check("rst.busy", 64'(bus.busy), 64'(0));
    check("rst.done", 64'(bus.done), 64'(0));
    check("rst.dbz", 64'(bus.dbz), 64'(0));
    rst_n = 1'b1;
    tick();

    run("u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         -1);
    tick();
    run("s-7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
    run("s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         -1);
    run("ubig",     1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, -1);
    run("sovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         -1);
    run("udbz",     1'b0, 32'd123,       32'd0,         32'd0,         32'd0,         -1);
    run("sdbz",     1'b1, 32'd123,       32'd0,         32'd0,         32'd0,         -1);
    run("ignstart", 1'b0, 32'd1000,      32'd10,        32'd100,       32'd0,          4);

    // Back-to-back: accept a new start in the DONE cycle.
    tick();
    run("b2b.1", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, -1);
    check("b2b.done_at_start", 64'(bus.done), 64'(1));
    start_op(1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF);
    tick();
    bus.start = 1'b0;
    check("b2b.busy", 64'(bus.busy), 64'(1));
    check("b2b.holdq", 64'(bus.q), 64'(32'hFFFF_FFF2));
    check("b2b.holdr", 64'(bus.r), 64'(32'hFFFF_FFFE));
    await_done("b2b.2", -1);

    // Reset in the middle of CALC aborts without a done pulse.
    tick();
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #2;
    check("abort.busy", 64'(bus.busy), 64'(0));
    check("abort.done", 64'(bus.done), 64'(0));
    check("abort.q", 64'(bus.q), 64'(0));
    check("abort.r", 64'(bus.r), 64'(0));
    tick();
    rst_n = 1'b1;
    dcnt  = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (bus.done === 1'b1) dcnt++;
    end
    check("abort.nodone", 64'(dcnt), 64'(0));
    run("post_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, -1);

    for (int n = 0; n < 400; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = -32'($urandom_range(1, 16));
        3:       rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'hFFFF_FFFF;
        default: begin
          rb = 32'($urandom_range(1, 7));
          ra = 32'h8000_0000;
        end
      endcase
      model(rs, ra, rb, rq, rr);
      run("rnd", rs, ra, rb, rq, rr, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divu_seq.md
Name: divu_seq

Overview:
- Multi-cycle iterative radix-2 restoring divider, signed or unsigned selectable per operation.
- Parametrised successor to the combinational divider in the MIPS datapath; feeds HI/LO for DIV/DIVU.
- Start/busy/done handshake lets the pipeline stall on busy instead of paying a single-cycle divide in the critical path.
- Result semantics match the combinational divider: truncation toward zero, divide-by-zero gives q=0, r=0.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  request; sampled only when idle or in DONE state
- sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- a  in  WIDTH  dividend; sampled with start
- b  in  WIDTH  divisor; sampled with start
- q  out  WIDTH  quotient, registered, held until next accepted start completes
- r  out  WIDTH  remainder, registered, held likewise
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when q/r are valid and updated
- dbz  out  1  divide-by-zero flag for the last result, valid with done, held

Behaviour:
- Reset (async assert, sync release) → state IDLE; q=0, r=0, busy=0, done=0, dbz=0; internal registers cleared. Reset mid-operation aborts; no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE, start=1 at edge T:
  - latch sign, a, b;
  - in signed mode, form magnitudes |a| and |b| and record neg_q = a[msb]^b[msb] and neg_r = a[msb];
  - latch zero_div = (b==0);
  - clear the partial remainder; set counter = WIDTH; go to CALC; busy=1 from T.
- CALC: one quotient bit per cycle, MSB first.
  - Shift {rem, dvd} left by 1.
  - If rem >= divisor magnitude: subtract and set quotient bit 1, else 0.
  - Compare uses a WIDTH+1-bit subtraction so unsigned divisors >= 2^(WIDTH-1) are handled.
  - Counter decrements each cycle; after WIDTH CALC cycles go to FIX.
- FIX (1 cycle): apply sign correction.
  - q = neg_q ? -qmag : qmag; r = neg_r ? -rmag : rmag (WIDTH-bit two's complement wrap).
  - If zero_div: q=0, r=0, dbz=1; else dbz=0. Go to DONE.
- Latency and output timing:
  - q/r/dbz register at the FIX edge.
  - In DONE: done=1 and busy=0 for exactly one cycle; next state is IDLE unless start=1.
  - Fixed latency for all operands, including divide-by-zero: start edge T → done high in cycle T+WIDTH+2; busy high for WIDTH+1 cycles.
- start while CALC or FIX is ignored; operands are not re-latched and the result is unaffected.
- start=1 during the DONE cycle is accepted back-to-back. done stays 1 for that cycle, busy rises next cycle, and q/r hold the previous result until the new FIX.
- Signed overflow: a = -2^(WIDTH-1), b = -1 → q = -2^(WIDTH-1) (wrap), r = 0. No trap.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), representable unsigned in WIDTH bits; no extra width is needed.
- Unsigned mode: sign bits ignored, neg_q = neg_r = 0.
- Remainder identity for every non-zero-divisor result: a == q*b + r (mod 2^WIDTH); |r| < |b|; r is zero or has the sign of a.
- Inputs a, b and sign may change freely after acceptance without affecting the running operation.

Test Plan:
- Unsigned (WIDTH=32), a=100, b=7, sign=0 → done in cycle T+34; q=14, r=2, dbz=0; busy high for 33 cycles.
- Signed truncation cases:
  - a=-7 (0xFFFFFFF9), b=2, sign=1 → q=-3 (0xFFFFFFFD), r=-1 (0xFFFFFFFF).
  - a=7, b=-2 → q=-3, r=1.
- Large unsigned and overflow:
  - a=0xFFFFFFFF, b=0x80000000, sign=0 → q=1, r=0x7FFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF, sign=1 → q=0x80000000, r=0.
- Divide by zero: a=123, b=0, sign in {0,1} → q=0, r=0, dbz=1, done still at T+34.
- Handshake:
  - Pulse start again at T+5 with different operands → ignored; first result correct.
  - Assert start in the DONE cycle → second result after another 34 cycles; q/r hold the first result in between.
- Reset at T+10 mid-CALC → busy=0, done never pulses, q=r=0. A subsequent start of 9/3 → q=3, r=0.
- Random regression, 10k operations per mode, WIDTH=32 and WIDTH=8 → matches the reference model (truncating divide, b==0 → 0/0) and the remainder identity holds.
